// File: rtl/lm_sm_pkg.sv
// Shared types and constants for the LM/SM memory sequencer.
package lm_sm_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int RIDX_W = 3;

  // Major opcodes of the two multi-register instructions
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lm_sm_addr_counter.sv
// Loadable, wrapping address counter; load has priority over increment.
module lm_sm_addr_counter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] count
);

  // Address register: wraps silently modulo 2^ADDR_W
  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (load) count <= load_val;
    else if (inc)  count <= count + 1'b1;
  end

endmodule

// File: rtl/lm_sm_mem_sequencer.sv
// LM/SM multi-cycle memory sequencer.
// Optional feature: define LM_SM_BASE_WRITEBACK_EN to write base+N back into
// the base register during the DONE cycle.
module lm_sm_mem_sequencer #(
  parameter int DATA_W = lm_sm_pkg::DATA_W,
  parameter int ADDR_W = lm_sm_pkg::ADDR_W,
  parameter int RIDX_W = lm_sm_pkg::RIDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [RIDX_W-1:0] base_reg,
  input  logic [RIDX_W-1:0] reg_idx,
  input  logic              list_valid,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [RIDX_W-1:0] rf_raddr,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              advance,
  output logic              busy,
  output logic              done
);
  import lm_sm_pkg::*;

  state_t            state;
  logic              ld_q;
  logic [RIDX_W-1:0] breg_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_load;
  logic              addr_inc;

  // Address only moves when an access actually completes
  assign addr_load = (state == IDLE) && start;
  assign addr_inc  = (state == XFER) && list_valid && mem_ready;

  lm_sm_addr_counter #(.ADDR_W(ADDR_W)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (addr_load),
    .inc      (addr_inc),
    .load_val (base_addr),
    .count    (addr_q)
  );

  // Control FSM; the list-exhausted XFER cycle leads into a single DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ld_q   <= 1'b0;
      breg_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ld_q   <= is_load;
          breg_q <= base_reg;
          state  <= XFER;
        end
        XFER: if (!list_valid) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef LM_SM_BASE_WRITEBACK_EN
  // Base register index only matters when writeback is built in
  logic unused_breg;
  assign unused_breg = ^breg_q;
`endif

  // Outputs are combinational so data passes through with no added latency
  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    rf_raddr  = '0;
    rf_waddr  = '0;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    advance   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      XFER: begin
        busy = 1'b1;
        if (list_valid) begin
          mem_addr = addr_q;
          advance  = mem_ready;
          if (ld_q) begin
            mem_rd   = 1'b1;
            rf_waddr = reg_idx;
            rf_wdata = mem_rdata;
            rf_we    = mem_ready;
          end else begin
            mem_wr    = 1'b1;
            rf_raddr  = reg_idx;
            mem_wdata = rf_rdata;
          end
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
`ifdef LM_SM_BASE_WRITEBACK_EN
        // Written after any LM load of the same register, so it wins
        rf_we    = 1'b1;
        rf_waddr = breg_q;
        rf_wdata = DATA_W'(addr_q);
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lm_sm_mem_sequencer.sv
module tb_lm_sm_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, is_load, list_valid, mem_ready;
  logic [15:0] base_addr, mem_rdata, rf_rdata, rf_seed;
  logic [2:0]  base_reg, reg_idx;
  logic [15:0] mem_addr, mem_wdata, rf_wdata;
  logic        mem_rd, mem_wr, rf_we, advance, busy, done;
  logic [2:0]  rf_raddr, rf_waddr;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign rf_rdata = rf_seed + 16'h0101 * {13'd0, rf_raddr};

  lm_sm_mem_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load),
    .base_addr(base_addr), .base_reg(base_reg), .reg_idx(reg_idx),
    .list_valid(list_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rf_rdata(rf_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .advance(advance), .busy(busy),
    .done(done)
  );

  task automatic run_op(input logic ld, input logic [15:0] base,
                        input logic [2:0] breg, input logic [7:0] mask,
                        input int stall_first, input int stall_pct);
    logic [2:0]  q[$];
    logic [15:0] ea, exp_wd;
    logic        rdy;
    int          n, k, stall_left;
    q = {};
    for (int r = 0; r < 8; r++) if (mask[r]) q.push_back(3'(r));
    n = q.size(); k = 0; stall_left = stall_first;
    rf_seed = 16'($urandom);
    @(posedge clk); #1;
    start = 1'b1; is_load = ld; base_addr = base; base_reg = breg;
    list_valid = 1'b0; mem_ready = 1'b0; reg_idx = 3'd0;
    @(negedge clk);
    n_tests++;
    if ({busy, done, mem_rd, mem_wr} !== 4'b0000) begin
      n_fail++;
      $display("FAIL start_cycle: got %b want 0000", {busy, done, mem_rd, mem_wr});
    end
    while (q.size() > 0) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0); is_load = 1'($urandom);
      base_addr = 16'($urandom); base_reg = 3'($urandom);
      list_valid = 1'b1; reg_idx = q[0];
      if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
      else rdy = ($urandom_range(0, 99) >= stall_pct);
      mem_ready = rdy; mem_rdata = 16'($urandom);
      ea = base + 16'(k);
      @(negedge clk);
      n_tests++;
      if ({busy, done, mem_rd, mem_wr, advance, mem_addr} !== {1'b1, 1'b0, ld, ~ld, rdy, ea}) begin
        n_fail++;
        $display("FAIL xfer_ctl k=%0d: got %b/%h want %b/%h", k,
                 {busy, done, mem_rd, mem_wr, advance}, mem_addr, {1'b1, 1'b0, ld, ~ld, rdy}, ea);
      end
      n_tests++;
      if (ld) begin
        if ({rf_we, rf_waddr, rf_wdata} !== {rdy, q[0], mem_rdata}) begin
          n_fail++;
          $display("FAIL lm_write k=%0d: got %b/%0d/%h want %b/%0d/%h", k,
                   rf_we, rf_waddr, rf_wdata, rdy, q[0], mem_rdata);
        end
      end else begin
        exp_wd = rf_seed + 16'h0101 * {13'd0, q[0]};
        if ({rf_we, rf_raddr, mem_wdata} !== {1'b0, q[0], exp_wd}) begin
          n_fail++;
          $display("FAIL sm_data k=%0d: got %b/%0d/%h want 0/%0d/%h", k,
                   rf_we, rf_raddr, mem_wdata, q[0], exp_wd);
        end
      end
      if (rdy) begin void'(q.pop_front()); k++; end
    end
    @(posedge clk); #1;
    start = ($urandom_range(0, 1) == 0); list_valid = 1'b0;
    reg_idx = 3'($urandom); mem_ready = 1'($urandom);
    @(negedge clk);
    n_tests++;
    if ({busy, done, mem_rd, mem_wr, advance, rf_we} !== 6'b100000) begin
      n_fail++;
      $display("FAIL list_empty: got %b want 100000", {busy, done, mem_rd, mem_wr, advance, rf_we});
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, done, mem_rd, mem_wr, advance} !== 5'b11000) begin
      n_fail++;
      $display("FAIL done_cycle: got %b want 11000", {busy, done, mem_rd, mem_wr, advance});
    end
    n_tests++;
`ifdef LM_SM_BASE_WRITEBACK_EN
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, breg, base + 16'(n)}) begin
      n_fail++;
      $display("FAIL writeback: got %b/%0d/%h want 1/%0d/%h", rf_we, rf_waddr, rf_wdata,
               breg, base + 16'(n));
    end
`else
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL no_writeback: got rf_we=%b want 0", rf_we);
    end
`endif
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, done, mem_rd, mem_wr} !== 4'b0000) begin
      n_fail++;
      $display("FAIL back_idle: got %b want 0000", {busy, done, mem_rd, mem_wr});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; is_load = 1'b1; base_addr = 16'h5555; base_reg = 3'd1;
    reg_idx = 3'd3; list_valid = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hABCD;
    rf_seed = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({mem_addr, mem_rd, mem_wr, mem_wdata, rf_raddr, rf_waddr, rf_we, rf_wdata,
         advance, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b rd=%b wr=%b addr=%h we=%b", busy, mem_rd,
               mem_wr, mem_addr, rf_we);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_lm_basic();
    run_op(1'b1, 16'h0040, 3'd0, 8'b0100_1010, 0, 0);
  endtask

  task automatic test_sm_stall();
    run_op(1'b0, 16'h0100, 3'd4, 8'b1000_0001, 2, 0);
  endtask

  task automatic test_empty();
    run_op(1'b1, 16'h1234, 3'd1, 8'h00, 0, 0);
    run_op(1'b0, 16'h4321, 3'd6, 8'h00, 0, 0);
  endtask

  task automatic test_wrap();
    run_op(1'b0, 16'hFFFF, 3'd3, 8'b0001_0100, 0, 0);
    run_op(1'b1, 16'hFFFE, 3'd0, 8'b1110_0000, 0, 0);
  endtask

  task automatic test_rst_mid();
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; base_addr = 16'h2000; base_reg = 3'd0;
    list_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; list_valid = 1'b1; reg_idx = 3'd1;
    @(posedge clk); #1;
    reg_idx = 3'd2; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_addr, mem_rd, mem_wr, mem_wdata, rf_raddr, rf_waddr, rf_we, rf_wdata,
         advance, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: got busy=%b rd=%b addr=%h we=%b adv=%b", busy, mem_rd,
               mem_addr, rf_we, advance);
    end
    run_op(1'b1, 16'h3000, 3'd5, 8'b0000_1110, 0, 0);
  endtask

  task automatic test_writeback();
    run_op(1'b1, 16'h0010, 3'd2, 8'b0010_0100, 0, 0);
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 25; i++)
      run_op(1'($urandom), 16'($urandom), 3'($urandom), 8'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 40));
  endtask

  initial begin
    test_reset();
    test_lm_basic();
    test_sm_stall();
    test_empty();
    test_wrap();
    test_rst_mid();
    test_writeback();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
